// File: rtl/multi_tick_div_pkg.sv
// multi_tick_div_pkg: shared channel FSM encodings and standard 50 MHz divisor constants.
package multi_tick_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ch_state_e;

    localparam int unsigned DIV_1S    = 50_000_000 - 1;
    localparam int unsigned DIV_100MS = 5_000_000 - 1;

endpackage

// File: rtl/multi_tick_div_tick_chan.sv
// tick_chan: one tick channel with FSM, counter, divisor, shadow divisor and registered tick.
module tick_chan
    import multi_tick_div_pkg::*;
#(
    parameter int unsigned       CNT_W       = 32,
    parameter logic [CNT_W-1:0]  DIV_DEFAULT = CNT_W'(DIV_1S)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             oneshot,
    input  logic             sync_clr,
    input  logic             load_we,
    input  logic [CNT_W-1:0] load_div,
    output logic             pending,
    output logic             tick,
    output logic             busy
);

    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, div_q, div_d, shadow_q, shadow_d;
    logic             pend_q, pend_d, oneshot_q, oneshot_d, tick_q, tick_d;
    logic             apply;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        shadow_d  = shadow_q;
        pend_d    = pend_q;
        oneshot_d = oneshot_q;
        tick_d    = 1'b0;
        apply     = 1'b0;
        if (sync_clr) begin
            cnt_d = '0;
            apply = 1'b1;
            if (!en) state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    apply = 1'b1;
                    if (en) begin
                        state_d   = ST_RUN;
                        oneshot_d = oneshot;
                    end
                end
                ST_RUN: begin
                    if (!en) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        apply   = 1'b1;
                    end else if (cnt_q == div_q) begin
                        cnt_d  = '0;
                        tick_d = 1'b1;
                        apply  = 1'b1;
                        if (oneshot_q) state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    cnt_d = '0;
                    apply = 1'b1;
                    if (!en) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
        if (apply && pend_q) begin
            div_d  = shadow_q;
            pend_d = 1'b0;
        end
        // A running channel only takes a new divisor at a period boundary.
        if (load_we) begin
            if (state_q == ST_RUN) begin
                shadow_d = load_div;
                pend_d   = 1'b1;
            end else begin
                div_d = load_div;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            div_q     <= DIV_DEFAULT;
            shadow_q  <= '0;
            pend_q    <= 1'b0;
            oneshot_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            shadow_q  <= shadow_d;
            pend_q    <= pend_d;
            oneshot_q <= oneshot_d;
            tick_q    <= tick_d;
        end
    end

    assign pending = pend_q;
    assign tick    = tick_q;
    assign busy    = (state_q == ST_RUN);

endmodule

// File: rtl/multi_tick_div.sv
// multi_tick_div: CH_NUM independent programmable tick channels with per-channel divisor loading.
module multi_tick_div
    import multi_tick_div_pkg::*;
#(
    parameter int unsigned      CH_NUM      = 4,
    parameter int unsigned      CNT_W       = 32,
    parameter logic [CNT_W-1:0] DIV_DEFAULT = CNT_W'(DIV_1S),
    localparam int unsigned     IDX_W       = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CH_NUM-1:0] ch_en,
    input  logic [CH_NUM-1:0] ch_oneshot,
    input  logic              sync_clr,
    input  logic              load_valid,
    input  logic [IDX_W-1:0]  load_ch,
    input  logic [CNT_W-1:0]  load_div,
    output logic              load_ready,
    output logic [CH_NUM-1:0] tick,
    output logic [CH_NUM-1:0] busy
);

    logic [CH_NUM-1:0]       pending;
    logic [(2**IDX_W)-1:0]   pend_ext;

    // Indices beyond CH_NUM see a zero pending flag, so such loads are accepted and dropped.
    always_comb begin
        pend_ext             = '0;
        pend_ext[CH_NUM-1:0] = pending;
    end

    assign load_ready = !pend_ext[load_ch];

    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        tick_chan #(
            .CNT_W       (CNT_W),
            .DIV_DEFAULT (DIV_DEFAULT)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (ch_en[i]),
            .oneshot  (ch_oneshot[i]),
            .sync_clr (sync_clr),
            .load_we  (load_valid && load_ready && (load_ch == IDX_W'(i))),
            .load_div (load_div),
            .pending  (pending[i]),
            .tick     (tick[i]),
            .busy     (busy[i])
        );
    end

endmodule

// File: tb/tb_multi_tick_div.sv
// tb_multi_tick_div: directed checks of periodic, one-shot, divisor load, sync_clr and reset behaviour.
module tb_multi_tick_div;

    localparam int CH_NUM = 5;
    localparam int CNT_W  = 32;
    localparam int IDX_W  = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [CH_NUM-1:0] ch_en = '0;
    logic [CH_NUM-1:0] ch_oneshot = '0;
    logic              sync_clr = 1'b0;
    logic              load_valid = 1'b0;
    logic [IDX_W-1:0]  load_ch = '0;
    logic [CNT_W-1:0]  load_div = '0;
    logic              load_ready;
    logic [CH_NUM-1:0] tick;
    logic [CH_NUM-1:0] busy;

    int n_cmp = 0;
    int n_err = 0;

    multi_tick_div #(
        .CH_NUM      (CH_NUM),
        .CNT_W       (CNT_W),
        .DIV_DEFAULT (32'd9)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ch_en      (ch_en),
        .ch_oneshot (ch_oneshot),
        .sync_clr   (sync_clr),
        .load_valid (load_valid),
        .load_ch    (load_ch),
        .load_div   (load_div),
        .load_ready (load_ready),
        .tick       (tick),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic idle_cycles(input int k);
        for (int j = 0; j < k; j++) @(negedge clk);
    endtask

    task automatic test_reset;
        idle_cycles(2);
        n_cmp++;
        if (tick !== '0 || busy !== '0 || load_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset: tick=%b busy=%b ready=%b, want 0/0/1", tick, busy, load_ready);
        end
        rst_n = 1'b1;
        idle_cycles(2);
    endtask

    task automatic test_periodic;
        logic exp;
        ch_en[0] = 1'b1;
        for (int n = 1; n <= 32; n++) begin
            @(negedge clk);
            exp = (n == 11 || n == 21 || n == 31);
            n_cmp++;
            if (tick[0] !== exp) begin
                n_err++;
                $display("FAIL periodic n=%0d: tick0=%b want %b", n, tick[0], exp);
            end
            if (n == 1) begin
                n_cmp++;
                if (busy[0] !== 1'b1) begin
                    n_err++;
                    $display("FAIL periodic_busy: busy0=%b want 1", busy[0]);
                end
            end
        end
        ch_en[0] = 1'b0;
        idle_cycles(2);
    endtask

    task automatic test_load_switch;
        logic exp_t, exp_r;
        ch_en[1] = 1'b1;
        load_ch  = 3'd1;
        for (int n = 1; n <= 25; n++) begin
            @(negedge clk);
            load_valid = 1'b0;
            exp_t = (n == 11 || n == 16 || n == 21);
            exp_r = !(n >= 4 && n <= 10);
            n_cmp++;
            if (tick[1] !== exp_t || load_ready !== exp_r) begin
                n_err++;
                $display("FAIL load_switch n=%0d: tick1=%b ready=%b want %b %b", n, tick[1], load_ready, exp_t, exp_r);
            end
            if (n == 3) begin
                load_valid = 1'b1;
                load_div   = 32'd4;
            end
        end
        ch_en[1] = 1'b0;
        idle_cycles(2);
    endtask

    task automatic test_oneshot;
        logic exp_t, exp_b;
        load_ch    = 3'd2;
        load_div   = 32'd3;
        load_valid = 1'b1;
        @(negedge clk);
        load_valid    = 1'b0;
        ch_oneshot[2] = 1'b1;
        for (int r = 0; r < 2; r++) begin
            ch_en[2] = 1'b1;
            for (int n = 1; n <= 15; n++) begin
                @(negedge clk);
                exp_t = (n == 5);
                exp_b = (n >= 1 && n <= 4);
                n_cmp++;
                if (tick[2] !== exp_t || busy[2] !== exp_b) begin
                    n_err++;
                    $display("FAIL oneshot r=%0d n=%0d: tick2=%b busy2=%b want %b %b", r, n, tick[2], busy[2], exp_t, exp_b);
                end
            end
            ch_en[2] = 1'b0;
            @(negedge clk);
        end
        ch_oneshot[2] = 1'b0;
        idle_cycles(1);
    endtask

    task automatic test_sync_clr;
        logic [1:0] exp;
        ch_en[1:0] = 2'b11;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            sync_clr = 1'b0;
            exp[0] = (n == 19 || n == 29);
            exp[1] = (n == 6 || n == 14 || n == 19 || n == 24 || n == 29);
            n_cmp++;
            if (tick[1:0] !== exp) begin
                n_err++;
                $display("FAIL sync_clr n=%0d: tick[1:0]=%b want %b", n, tick[1:0], exp);
            end
            if (n == 8) sync_clr = 1'b1;
        end
        ch_en[1:0] = 2'b00;
        idle_cycles(2);
    endtask

    task automatic test_div0_and_oob;
        logic [3:0] exp;
        load_ch    = 3'd3;
        load_div   = 32'd0;
        load_valid = 1'b1;
        @(negedge clk);
        load_ch  = 3'd5;
        load_div = 32'd7;
        n_cmp++;
        if (load_ready !== 1'b1) begin
            n_err++;
            $display("FAIL oob_ready: ready=%b want 1", load_ready);
        end
        @(negedge clk);
        load_valid = 1'b0;
        ch_en[3:0] = 4'b1011;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            exp    = '0;
            exp[3] = (n >= 2);
            exp[1] = (n == 6 || n == 11);
            exp[0] = (n == 11);
            n_cmp++;
            if (tick[3:0] !== exp) begin
                n_err++;
                $display("FAIL div0_oob n=%0d: tick[3:0]=%b want %b", n, tick[3:0], exp);
            end
        end
        ch_en = '0;
        idle_cycles(2);
    endtask

    task automatic test_reset_midcount;
        logic [CH_NUM-1:0] exp;
        ch_en[0] = 1'b1;
        ch_en[3] = 1'b1;
        load_ch  = 3'd0;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            load_valid = 1'b0;
            if (n == 4) begin
                load_valid = 1'b1;
                load_div   = 32'd2;
            end
        end
        n_cmp++;
        if (load_ready !== 1'b0 || tick[3] !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset: ready=%b tick3=%b want 0 1", load_ready, tick[3]);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (tick !== '0 || busy !== '0 || load_ready !== 1'b1) begin
            n_err++;
            $display("FAIL async_reset: tick=%b busy=%b ready=%b want 0/0/1", tick, busy, load_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            exp = (n == 11) ? 5'b01001 : 5'b00000;
            n_cmp++;
            if (tick !== exp) begin
                n_err++;
                $display("FAIL post_reset n=%0d: tick=%b want %b", n, tick, exp);
            end
        end
        ch_en = '0;
        idle_cycles(2);
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_load_switch();
        test_oneshot();
        test_sync_clr();
        test_div0_and_oob();
        test_reset_midcount();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
